// File: rtl/dot_matrix_scan_controller.sv
// dot_matrix_scan_controller
//   Scans an 8x8 LED dot matrix one row per prescaler tick. The frame store is
//   double-buffered. Producer logic writes rows into the back buffer and then
//   requests a swap. The swap is deferred to the next frame end, so a displayed
//   frame is never torn.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | writes accepted; a swap request moves to PEND
//   PEND  | writes dropped; the swap happens on the next frame-end tick
//
// Ports
//   Clock        in   system clock, posedge
//   Reset        in   synchronous, active-high
//   Wr_En        in   back-buffer row write strobe
//   Wr_Row[2:0]  in   row to write (0 = top)
//   Wr_Data[7:0] in   column pattern, bit7 = leftmost, 1 = on
//   Wr_Ready     out  writes accepted (state RUN)
//   Swap_Req     in   single-cycle request to display the back buffer
//   Swap_Ack     out  one-cycle pulse when the swap has taken effect
//   Blank        in   forces columns off on scanned rows
//   Frame_Start  out  one-cycle pulse when row 0 is driven
//   Dot_Row[7:0] out  active-low one-hot row select
//   Dot_Col[7:0] out  active-high column data
module dot_matrix_scan_controller #(
  parameter int CLK_DIV = 5000,
  parameter int CNT_W   = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Wr_En,
  input  logic [2:0] Wr_Row,
  input  logic [7:0] Wr_Data,
  output logic       Wr_Ready,
  input  logic       Swap_Req,
  output logic       Swap_Ack,
  input  logic       Blank,
  output logic       Frame_Start,
  output logic [7:0] Dot_Row,
  output logic [7:0] Dot_Col
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] presc;
  logic             tick;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic             frame_end;
  logic             swap_now;
  logic             wr_accept;
  logic             front_sel;
  logic             front_sel_next;
  logic [7:0]       frame_buf [2][8];

  assign tick      = (presc == PRESC_LAST);
  assign idx_next  = idx + 3'd1;
  assign frame_end = tick && (idx == 3'd7);

  always_comb begin
    state_next = state;
    Wr_Ready   = 1'b0;
    swap_now   = 1'b0;
    case (state)
      RUN: begin
        Wr_Ready = 1'b1;
        if (Swap_Req) state_next = PEND;
      end
      PEND: begin
        if (frame_end) begin
          swap_now   = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign wr_accept      = Wr_En && Wr_Ready;
  // Row 0 of the swap tick must already come from the new front buffer,
  // so the scan read uses the post-swap select.
  assign front_sel_next = front_sel ^ swap_now;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= RUN;
      presc       <= '0;
      idx         <= 3'd7;
      front_sel   <= 1'b0;
      Dot_Row     <= 8'hFF;
      Dot_Col     <= 8'h00;
      Swap_Ack    <= 1'b0;
      Frame_Start <= 1'b0;
      for (int r = 0; r < 8; r++) begin
        frame_buf[0][r] <= 8'h00;
        frame_buf[1][r] <= 8'h00;
      end
    end else begin
      state       <= state_next;
      front_sel   <= front_sel_next;
      Swap_Ack    <= swap_now;
      Frame_Start <= frame_end;
      presc       <= tick ? '0 : presc + PRESC_ONE;
      if (wr_accept) frame_buf[~front_sel][Wr_Row] <= Wr_Data;
      if (tick) begin
        idx     <= idx_next;
        Dot_Row <= ~(8'h80 >> idx_next);
        Dot_Col <= Blank ? 8'h00 : frame_buf[front_sel_next][idx_next];
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_scan_controller.sv
// tb_dot_matrix_scan_controller
//   Bench for the dot matrix scan controller with CLK_DIV = 4. A reference
//   model tracks cycles since reset, tick count, the two frame images and the
//   pending-swap flag, and predicts every output after each clock edge.
module tb_dot_matrix_scan_controller;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       swap_req = 1'b0;
  logic       blank = 1'b0;
  logic       wr_ready, swap_ack, frame_start;
  logic [7:0] dot_row, dot_col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_matrix_scan_controller #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
    .Clock(clk), .Reset(rst), .Wr_En(wr_en), .Wr_Row(wr_row), .Wr_Data(wr_data),
    .Wr_Ready(wr_ready), .Swap_Req(swap_req), .Swap_Ack(swap_ack), .Blank(blank),
    .Frame_Start(frame_start), .Dot_Row(dot_row), .Dot_Col(dot_col)
  );

  // reference model state
  int unsigned m_cyc;
  int unsigned m_ticks;
  logic [7:0]  m_img [2][8];
  int          m_fs;
  bit          m_pend;
  logic [7:0]  e_row, e_col;
  bit          e_ack, e_fs;

  task automatic model_step();
    bit         pend_old, tk;
    int         r;
    logic [7:0] sel;
    if (rst) begin
      m_cyc = 0; m_ticks = 0; m_fs = 0; m_pend = 0;
      for (int i = 0; i < 8; i++) begin m_img[0][i] = 8'h00; m_img[1][i] = 8'h00; end
      e_row = 8'hFF; e_col = 8'h00; e_ack = 0; e_fs = 0;
    end else begin
      pend_old = m_pend;
      tk = (m_cyc % CLK_DIV) == CLK_DIV - 1;
      e_ack = 0; e_fs = 0;
      if (wr_en && !pend_old) m_img[1 - m_fs][wr_row] = wr_data;
      if (pend_old && tk && (m_ticks % 8 == 0)) begin
        m_fs = 1 - m_fs; m_pend = 0; e_ack = 1;
      end else if (!pend_old && swap_req) begin
        m_pend = 1;
      end
      if (tk) begin
        r = m_ticks % 8;
        sel = 8'h80;
        sel = sel >> r;
        e_row = ~sel;
        e_col = blank ? 8'h00 : m_img[m_fs][r];
        e_fs = (r == 0);
        m_ticks++;
      end
      m_cyc++;
    end
  endtask

  // apply the currently driven inputs to the model, then let the DUT clock
  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [18:0] obs();
    return {dot_row, dot_col, wr_ready, swap_ack, frame_start};
  endfunction

  function automatic logic [18:0] expv();
    return {e_row, e_col, !m_pend, e_ack, e_fs};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) advance();
    checks++;
    if (obs() !== {8'hFF, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values got %h want %h", obs(), {8'hFF, 8'h00, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_scan();
    int         last_fs = 0;
    logic [7:0] sel;
    rst = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      advance();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL scan_model k=%0d got %h want %h", k, obs(), expv());
      end
      sel = 8'h80;
      sel = (k < 4) ? 8'h00 : (sel >> (((k / 4) - 1) % 8));
      checks++;
      if (dot_row !== ~sel) begin
        errors++; $display("FAIL scan_row k=%0d got %h want %h", k, dot_row, ~sel);
      end
      if (frame_start) begin
        checks++;
        if ((last_fs == 0 && k != 4) || (last_fs != 0 && k - last_fs != 32)) begin
          errors++; $display("FAIL frame_start_period k=%0d got prev %0d want spacing 32", k, last_fs);
        end
        last_fs = k;
      end
    end
  endtask

  // waits for the next Frame_Start (bounded), comparing every cycle
  task automatic sync_frame(input string name);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      advance();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL %s_sync got %h want %h", name, obs(), expv());
      end
      seen = frame_start;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_sync got no frame_start want one in 40 clocks", name); end
  endtask

  // waits for Swap_Ack (bounded), comparing every cycle
  task automatic wait_ack(input string name);
    bit seen = 0;
    for (int k = 0; k < 8 * CLK_DIV + 4 && !seen; k++) begin
      advance();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL %s_wait got %h want %h", name, obs(), expv());
      end
      seen = swap_ack;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_ack got none want swap_ack within %0d clocks", name, 8 * CLK_DIV + 4); end
  endtask

  task automatic test_image();
    logic [7:0] img [8];
    logic [7:0] sel;
    img = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};
    sync_frame("image");
    for (int r = 0; r < 8; r++) begin
      wr_en = 1'b1; wr_row = 3'(r); wr_data = img[r];
      advance();
    end
    wr_en = 1'b0;
    swap_req = 1'b1; advance(); swap_req = 1'b0;
    wait_ack("image");
    for (int r = 0; r < 8; r++) begin
      if (r > 0) for (int c = 0; c < CLK_DIV; c++) advance();
      sel = 8'h80;
      sel = sel >> r;
      checks++;
      if (dot_row !== ~sel || dot_col !== img[r]) begin
        errors++; $display("FAIL image_row%0d got %h/%h want %h/%h", r, dot_row, dot_col, ~sel, img[r]);
      end
    end
  endtask

  task automatic test_write_pend();
    sync_frame("wpend");
    swap_req = 1'b1; advance(); swap_req = 1'b0;
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hFF;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL wpend_ready got %b want 0", wr_ready); end
    advance();
    wr_en = 1'b0;
    wait_ack("wpend");
    for (int c = 0; c < 4 * CLK_DIV; c++) begin
      advance();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL wpend_frame got %h want %h", obs(), expv()); end
    end
  endtask

  task automatic test_same_cycle();
    wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'hA5; swap_req = 1'b1;
    advance();
    wr_en = 1'b0; swap_req = 1'b0;
    wait_ack("same");
    for (int c = 0; c < 2 * CLK_DIV; c++) advance();
    checks++;
    if (dot_row !== 8'hDF || dot_col !== 8'hA5) begin
      errors++; $display("FAIL same_cycle_row2 got %h/%h want DF/A5", dot_row, dot_col);
    end
  endtask

  task automatic test_blank();
    blank = 1'b1;
    for (int k = 1; k <= 8 * CLK_DIV + CLK_DIV; k++) begin
      advance();
      checks++;
      if (obs() !== expv() || (k > CLK_DIV && dot_col !== 8'h00)) begin
        errors++; $display("FAIL blank k=%0d got %h want %h", k, obs(), expv());
      end
    end
    blank = 1'b0;
    for (int k = 0; k < 2 * CLK_DIV; k++) begin
      advance();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL unblank got %h want %h", obs(), expv()); end
    end
  endtask

  task automatic test_reset_pend();
    sync_frame("rpend");
    swap_req = 1'b1; advance(); swap_req = 1'b0;
    advance();
    rst = 1'b1; advance(); rst = 1'b0;
    checks++;
    if (obs() !== {8'hFF, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rpend_reset got %h want %h", obs(), {8'hFF, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      advance();
      checks++;
      if (obs() !== expv() || swap_ack !== 1'b0 || dot_col !== 8'h00) begin
        errors++; $display("FAIL rpend_dark got %h want %h", obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      wr_en    = ($urandom_range(3) == 0);
      wr_row   = 3'($urandom_range(7));
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(24) == 0);
      if ($urandom_range(40) == 0) blank = ~blank;
      advance();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random k=%0d got %h want %h", k, obs(), expv()); end
    end
    wr_en = 1'b0; swap_req = 1'b0; blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_image();
    test_write_pend();
    test_same_cycle();
    test_blank();
    test_reset_pend();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
